pe_cluster_ctrl: RTL and testbench

PE_CLUSTER_CTRL -- requirements
Module: pe_cluster_ctrl

---
 rtl/pe_cluster_ctrl.sv | 140 ++++++++++++++
 tb/tb_pe_cluster_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_cluster_ctrl.sv
// PE cluster job controller: clears the PEs, streams IFM words from a source,
// strobes end-of-accumulation and waits (with timeout) for all 16 OFM values.
module pe_cluster_ctrl #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic        abort,
    input  logic        rd_valid,
    input  logic [31:0] ifm_in,
    output logic        rd_en,
    output logic [31:0] IFM,
    output logic [15:0] PE_reset,
    output logic [15:0] PE_finish,
    input  logic [15:0] valid,
    output logic        ofm_latch,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_FINISH,
        S_WAIT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   nw_q, nw_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
    logic [31:0]   ifm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nw_q    <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            ifm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nw_q    <= nw_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            // zero-insertion keeps source stalls from disturbing the accumulators
            ifm_q   <= rd_en ? ifm_in : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nw_d      = nw_q;
        wcnt_d    = wcnt_q;
        err_d     = err_q;
        rd_en     = 1'b0;
        PE_reset  = '0;
        PE_finish = '0;
        ofm_latch = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    nw_d    = num_words;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                PE_reset = '1;
                state_d  = (nw_q == '0) ? S_DRAIN : S_ACCUM;
            end
            S_ACCUM: begin
                rd_en = rd_valid;
                if (rd_valid) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == nw_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_FINISH;
            S_FINISH: begin
                PE_finish = '1;
                wcnt_d    = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (valid == 16'hFFFF) begin
                    ofm_latch = 1'b1;
                    state_d   = S_DONE;
                end else if (wcnt_q == WW'(WAIT_MAX - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                PE_reset = '1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // abort overrides every transition and suppresses the strobes of this cycle
        if (abort && state_q != S_IDLE && state_q != S_ABORT) begin
            state_d   = S_ABORT;
            rd_en     = 1'b0;
            PE_finish = '0;
            ofm_latch = 1'b0;
            done      = 1'b0;
            cnt_d     = cnt_q;
            wcnt_d    = wcnt_q;
            err_d     = err_q;
        end
    end

    assign IFM   = ifm_q;
    assign busy  = (state_q != S_IDLE);
    assign error = err_q;

endmodule

// File: tb/tb_pe_cluster_ctrl.sv
// Randomized job-level bench for pe_cluster_ctrl: each job's expected cycle
// sequence is derived from its parameters and the randomly drawn source stalls.
module tb_pe_cluster_ctrl;

    localparam int WAIT_MAX = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] num_words;
    logic        abort;
    logic        rd_valid;
    logic [31:0] ifm_in;
    logic        rd_en;
    logic [31:0] IFM;
    logic [15:0] PE_reset;
    logic [15:0] PE_finish;
    logic [15:0] valid;
    logic        ofm_latch;
    logic        busy;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    pe_cluster_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_words (num_words),
        .abort     (abort),
        .rd_valid  (rd_valid),
        .ifm_in    (ifm_in),
        .rd_en     (rd_en),
        .IFM       (IFM),
        .PE_reset  (PE_reset),
        .PE_finish (PE_finish),
        .valid     (valid),
        .ofm_latch (ofm_latch),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] partial_valid();
        logic [15:0] pv;
        pv = 16'($urandom);
        pv[$urandom_range(0, 15)] = 1'b0;
        return pv;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_IFM"}, IFM, 32'h0);
        check({tag, "_PE_reset"}, {16'h0, PE_reset}, 32'h0);
        check({tag, "_PE_finish"}, {16'h0, PE_finish}, 32'h0);
        check({tag, "_rd_en"}, {31'h0, rd_en}, 32'h0);
        check({tag, "_ofm_latch"}, {31'h0, ofm_latch}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_error"}, {31'h0, error}, 32'h0);
    endtask

    // nw: words; stall_pct: chance (%) of rd_valid=0; wait_cycles: WAIT cycles before
    // valid=FFFF (>= WAIT_MAX means never); abort_after: abort once this many words
    // were consumed (-1 none); rst_at: assert reset_n in that WAIT cycle (-1 none)
    task automatic run_job(input int nw, input int stall_pct, input int wait_cycles,
                           input int abort_after, input bit busy_start, input int rst_at);
        logic [31:0] last_ifm;
        int          consumed;
        int          guard;
        bit          exp_err;
        exp_err = 1'b0;

        @(negedge clk);
        start = 1'b1; num_words = 16'(nw); abort = 1'b0;
        rd_valid = 1'($urandom_range(0, 1)); ifm_in = $urandom;
        #1;
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_rd_en", {31'h0, rd_en}, 32'h0);

        @(negedge clk);
        start = 1'b0; num_words = 16'($urandom); rd_valid = 1'($urandom_range(0, 1));
        #1;
        check("clr_PE_reset", {16'h0, PE_reset}, 32'h0000FFFF);
        check("clr_busy", {31'h0, busy}, 32'h1);
        check("clr_rd_en", {31'h0, rd_en}, 32'h0);
        check("clr_error", {31'h0, error}, 32'h0);

        last_ifm = 32'h0;
        consumed = 0;
        guard    = 0;
        while (consumed < nw) begin
            @(negedge clk);
            rd_valid  = (guard > 20) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            ifm_in    = $urandom;
            start     = busy_start && ($urandom_range(0, 2) == 0);
            num_words = 16'($urandom);
            abort     = (abort_after >= 0 && consumed == abort_after);
            #1;
            check("acc_IFM", IFM, last_ifm);
            check("acc_PE_reset", {16'h0, PE_reset}, 32'h0);
            if (abort) begin
                check("abt_rd_en", {31'h0, rd_en}, 32'h0);
                @(negedge clk);
                abort = 1'b0; start = 1'b0; rd_valid = 1'b1;
                #1;
                check("abt_PE_reset", {16'h0, PE_reset}, 32'h0000FFFF);
                check("abt_IFM", IFM, 32'h0);
                check("abt_done", {31'h0, done}, 32'h0);
                check("abt_rd_en2", {31'h0, rd_en}, 32'h0);
                @(negedge clk);
                #1;
                check("abt_idle_busy", {31'h0, busy}, 32'h0);
                check("abt_idle_PE_reset", {16'h0, PE_reset}, 32'h0);
                check("abt_idle_done", {31'h0, done}, 32'h0);
                return;
            end
            check("acc_rd_en", {31'h0, rd_en}, {31'h0, rd_valid});
            if (rd_valid) begin
                last_ifm = ifm_in;
                consumed++;
                guard = 0;
            end else begin
                last_ifm = 32'h0;
                guard++;
            end
        end

        @(negedge clk);
        start = 1'b0; rd_valid = 1'($urandom_range(0, 1)); ifm_in = $urandom;
        #1;
        check("drn_rd_en", {31'h0, rd_en}, 32'h0);
        check("drn_IFM", IFM, last_ifm);
        check("drn_PE_finish", {16'h0, PE_finish}, 32'h0);

        @(negedge clk);
        rd_valid = 1'($urandom_range(0, 1));
        #1;
        check("fin_PE_finish", {16'h0, PE_finish}, 32'h0000FFFF);
        check("fin_IFM", IFM, 32'h0);
        check("fin_rd_en", {31'h0, rd_en}, 32'h0);

        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            valid = (i == wait_cycles) ? 16'hFFFF : partial_valid();
            rd_valid = 1'($urandom_range(0, 1));
            #1;
            if (i == rst_at) begin
                reset_n = 1'b0;
                #1;
                check_all_zero("rst_wait");
                @(negedge clk);
                #1;
                check("rst_wait_done", {31'h0, done}, 32'h0);
                reset_n = 1'b1;
                return;
            end
            if (i == 0) check("wait_PE_finish", {16'h0, PE_finish}, 32'h0);
            if (i == wait_cycles) begin
                check("wait_latch", {31'h0, ofm_latch}, 32'h1);
                break;
            end
            check("wait_nolatch", {31'h0, ofm_latch}, 32'h0);
            check("wait_done", {31'h0, done}, 32'h0);
            if (i == WAIT_MAX - 1) exp_err = 1'b1;
        end

        @(negedge clk);
        valid = 16'($urandom);
        #1;
        check("done_pulse", {31'h0, done}, 32'h1);
        check("done_latch", {31'h0, ofm_latch}, 32'h0);
        check("done_error", {31'h0, error}, {31'h0, exp_err});
        check("done_busy", {31'h0, busy}, 32'h1);

        @(negedge clk);
        valid = 16'h0;
        #1;
        check("post_done", {31'h0, done}, 32'h0);
        check("post_busy", {31'h0, busy}, 32'h0);
        check("post_error", {31'h0, error}, {31'h0, exp_err});
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; rd_valid = 1'b1;
        num_words = 16'd5; ifm_in = 32'hDEADBEEF; valid = 16'hFFFF;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        // abort and start-free cycles in IDLE do nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("idle_abort_busy", {31'h0, busy}, 32'h0);
        check("idle_abort_PE_reset", {16'h0, PE_reset}, 32'h0);

        run_job(4, 0, 2, -1, 1'b0, -1);
        run_job(3, 50, 0, -1, 1'b0, -1);
        run_job(0, 0, 1, -1, 1'b0, -1);
        run_job(2, 30, 1000, -1, 1'b0, -1);
        @(negedge clk);
        #1;
        check("timeout_sticky", {31'h0, error}, 32'h1);
        run_job(1, 0, 0, -1, 1'b0, -1);
        run_job(5, 0, 1000, -1, 1'b0, -1);
        reset_n = 1'b0;
        #1;
        check("reset_clears_error", {31'h0, error}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_job(6, 20, 0, 2, 1'b0, -1);
        run_job(8, 30, 3, -1, 1'b1, -1);
        run_job(3, 10, 1000, -1, 1'b0, 7);

        for (int j = 0; j < 25; j++) begin
            int nw;
            int wc;
            int ab;
            nw = $urandom_range(0, 12);
            wc = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 20);
            ab = (nw > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, nw - 1) : -1;
            run_job(nw, $urandom_range(0, 60), wc, ab, 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
